// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt sequencer and single-write-port arbiter.
// Optional event counter output exc_cnt_o when CP0_EXC_STAT_EN is defined.
module cp0_exc_ctrl #(
   parameter logic [31:0] EXC_VECTOR      = 32'h0000_0020,
   parameter logic [4:0]  CP0_EPC_ADDR    = 5'd14,
   parameter logic [4:0]  CP0_CAUSE_ADDR  = 5'd13,
   parameter logic [4:0]  CP0_STATUS_ADDR = 5'd12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_valid_i,
   input  logic [31:0] inst_pc_i,
   input  logic        in_delay_slot_i,
   input  logic        exc_req_i,
   input  logic [4:0]  exc_code_i,
   input  logic        eret_i,
   input  logic [31:0] status_i,
   input  logic [31:0] cause_i,
   input  logic [31:0] epc_i,
   input  logic        mtc0_we_i,
   input  logic [4:0]  mtc0_addr_i,
   input  logic [31:0] mtc0_data_i,
   output logic        cp0_we_o,
   output logic [4:0]  cp0_waddr_o,
   output logic [31:0] cp0_data_o,
   output logic        cp0_exc_wr_o,
   output logic        stall_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o
`ifdef CP0_EXC_STAT_EN
   ,
   output logic [15:0] exc_cnt_o
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      W_EPC,
      W_CAUSE,
      W_STATUS,
      W_ERET,
      FLUSH_X,
      FLUSH_E
   } state_t;

   state_t      state, state_n;
   logic [31:0] epc_val_q;
   logic [4:0]  code_q;
   logic        bd_q;
   logic [31:0] eret_pc_q;

   logic int_pend;
   logic take;
   logic take_exc;
   logic unused_cause_bits;

   assign int_pend = status_i[0] & ~status_i[1] & (|(cause_i[15:8] & status_i[15:8]));
   assign take     = ~rst & (state == IDLE) & inst_valid_i & (int_pend | exc_req_i | eret_i);
   assign take_exc = int_pend | exc_req_i;
   assign unused_cause_bits = ^{cause_i[31], cause_i[6:2]};

   // State and captured commit context
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         epc_val_q <= '0;
         code_q    <= '0;
         bd_q      <= 1'b0;
         eret_pc_q <= '0;
      end else begin
         state <= state_n;
         if (take) begin
            epc_val_q <= in_delay_slot_i ? 32'(inst_pc_i - 32'd4) : inst_pc_i;
            code_q    <= int_pend ? 5'd0 : exc_code_i;
            bd_q      <= in_delay_slot_i;
         end
         if (state == W_ERET) begin
            eret_pc_q <= epc_i;
         end
      end
   end

   // Next-state and output decode
   always_comb begin
      state_n      = state;
      cp0_we_o     = 1'b0;
      cp0_waddr_o  = '0;
      cp0_data_o   = '0;
      cp0_exc_wr_o = 1'b0;
      stall_o      = 1'b0;
      flush_o      = 1'b0;
      new_pc_o     = '0;
      case (state)
         IDLE: begin
            if (!rst) begin
               cp0_we_o    = mtc0_we_i;
               cp0_waddr_o = mtc0_addr_i;
               cp0_data_o  = mtc0_data_i;
            end
            stall_o = take;
            if (take) begin
               if (take_exc) begin
                  // With EXL already set the original EPC must be preserved
                  state_n = status_i[1] ? W_CAUSE : W_EPC;
               end else begin
                  state_n = W_ERET;
               end
            end
         end
         W_EPC: begin
            cp0_we_o    = 1'b1;
            cp0_waddr_o = CP0_EPC_ADDR;
            cp0_data_o  = epc_val_q;
            stall_o     = 1'b1;
            state_n     = W_CAUSE;
         end
         W_CAUSE: begin
            cp0_we_o     = 1'b1;
            cp0_waddr_o  = CP0_CAUSE_ADDR;
            cp0_data_o   = {bd_q, cause_i[30:7], code_q, cause_i[1:0]};
            cp0_exc_wr_o = 1'b1;
            stall_o      = 1'b1;
            state_n      = W_STATUS;
         end
         W_STATUS: begin
            cp0_we_o    = 1'b1;
            cp0_waddr_o = CP0_STATUS_ADDR;
            cp0_data_o  = status_i | 32'h0000_0002;
            stall_o     = 1'b1;
            state_n     = FLUSH_X;
         end
         W_ERET: begin
            cp0_we_o    = 1'b1;
            cp0_waddr_o = CP0_STATUS_ADDR;
            cp0_data_o  = status_i & ~32'h0000_0002;
            stall_o     = 1'b1;
            state_n     = FLUSH_E;
         end
         FLUSH_X: begin
            flush_o  = 1'b1;
            new_pc_o = EXC_VECTOR;
            state_n  = IDLE;
         end
         FLUSH_E: begin
            flush_o  = 1'b1;
            new_pc_o = eret_pc_q;
            state_n  = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

`ifdef CP0_EXC_STAT_EN
   // Saturating count of exception/interrupt redirects
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exc_cnt_o <= '0;
      end else if (state == FLUSH_X && exc_cnt_o != 16'hFFFF) begin
         exc_cnt_o <= exc_cnt_o + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Scoreboard bench for cp0_exc_ctrl: per-cycle expected outputs queued at drive time.
module tb_cp0_exc_ctrl;

   typedef struct packed {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] data;
      logic        exc_wr;
      logic        stall;
      logic        flush;
      logic [31:0] pc;
   } obs_t;

   logic        clk;
   logic        rst;
   logic        inst_valid;
   logic [31:0] inst_pc;
   logic        in_ds;
   logic        exc_req;
   logic [4:0]  exc_code;
   logic        eret;
   logic [31:0] status;
   logic [31:0] cause;
   logic [31:0] epc;
   logic        mtc0_we;
   logic [4:0]  mtc0_addr;
   logic [31:0] mtc0_data;
   logic        cp0_we;
   logic [4:0]  cp0_waddr;
   logic [31:0] cp0_data;
   logic        cp0_exc_wr;
   logic        stall;
   logic        flush;
   logic [31:0] new_pc;
`ifdef CP0_EXC_STAT_EN
   logic [15:0] exc_cnt;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   obs_t  exp_q[$];
   string name_q[$];

   cp0_exc_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .inst_valid_i    (inst_valid),
      .inst_pc_i       (inst_pc),
      .in_delay_slot_i (in_ds),
      .exc_req_i       (exc_req),
      .exc_code_i      (exc_code),
      .eret_i          (eret),
      .status_i        (status),
      .cause_i         (cause),
      .epc_i           (epc),
      .mtc0_we_i       (mtc0_we),
      .mtc0_addr_i     (mtc0_addr),
      .mtc0_data_i     (mtc0_data),
      .cp0_we_o        (cp0_we),
      .cp0_waddr_o     (cp0_waddr),
      .cp0_data_o      (cp0_data),
      .cp0_exc_wr_o    (cp0_exc_wr),
      .stall_o         (stall),
      .flush_o         (flush),
      .new_pc_o        (new_pc)
`ifdef CP0_EXC_STAT_EN
      ,
      .exc_cnt_o       (exc_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: compare queued expectation against DUT mid-cycle
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         obs_t  e;
         obs_t  g;
         string nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         g  = '{we: cp0_we, waddr: cp0_waddr, data: cp0_data, exc_wr: cp0_exc_wr,
                stall: stall, flush: flush, pc: new_pc};
         n_assert++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL %s: got we=%b a=%0d d=%h xw=%b st=%b fl=%b pc=%h, expected we=%b a=%0d d=%h xw=%b st=%b fl=%b pc=%h",
                     nm, g.we, g.waddr, g.data, g.exc_wr, g.stall, g.flush, g.pc,
                     e.we, e.waddr, e.data, e.exc_wr, e.stall, e.flush, e.pc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_cyc(input string nm, input logic we, input logic [4:0] a,
                             input logic [31:0] d, input logic xw, input logic st,
                             input logic fl, input logic [31:0] pc);
      obs_t e;
      e.we = we; e.waddr = a; e.data = d; e.exc_wr = xw;
      e.stall = st; e.flush = fl; e.pc = pc;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic clr_in();
      inst_valid = 1'b0; inst_pc = '0; in_ds = 1'b0; exc_req = 1'b0; exc_code = '0;
      eret = 1'b0; mtc0_we = 1'b0; mtc0_addr = '0; mtc0_data = '0;
   endtask

   task automatic drain();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clr_in();
      status = 32'h0000_0401; cause = 32'h0000_0400; epc = '0;
      inst_valid = 1'b1; exc_req = 1'b1; mtc0_we = 1'b1; mtc0_addr = 5'd9; mtc0_data = 32'h1234;
      #12;
      n_assert++;
      if (cp0_we !== 1'b0 || cp0_waddr !== 5'd0 || cp0_data !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_write_port: got we=%b a=%0d d=%h, expected 0", cp0_we, cp0_waddr, cp0_data);
      end
      n_assert++;
      if (stall !== 1'b0 || flush !== 1'b0 || cp0_exc_wr !== 1'b0 || new_pc !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got st=%b fl=%b xw=%b pc=%h, expected 0", stall, flush, cp0_exc_wr, new_pc);
      end
`ifdef CP0_EXC_STAT_EN
      n_assert++;
      if (exc_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_cnt: got %0d, expected 0", exc_cnt);
      end
`endif
      tick();
      clr_in();
      status = '0; cause = '0;
      rst = 1'b0;
      expect_cyc("post_reset_idle", 0, 0, 0, 0, 0, 0, 0);
      drain();
   endtask

   task automatic test_interrupt();
      tick(); status = 32'h0000_0401; cause = 32'h0000_0400; inst_valid = 1'b1; inst_pc = 32'h100;
      expect_cyc("int_take", 0, 0, 0, 0, 1, 0, 0);
      tick(); clr_in();
      expect_cyc("int_epc", 1, 14, 32'h100, 0, 1, 0, 0);
      tick(); mtc0_we = 1'b1; mtc0_addr = 5'd12; mtc0_data = 32'hFFFF_FFFF;
      expect_cyc("int_cause_ignores_mtc0", 1, 13, 32'h400, 1, 1, 0, 0);
      tick(); clr_in();
      expect_cyc("int_status", 1, 12, 32'h403, 0, 1, 0, 0);
      tick();
      expect_cyc("int_flush", 0, 0, 0, 0, 0, 1, 32'h20);
      tick(); status = '0; cause = '0;
      expect_cyc("int_idle", 0, 0, 0, 0, 0, 0, 0);
      drain();
   endtask

   task automatic test_exc_delay_slot();
      tick(); exc_req = 1'b1; exc_code = 5'd8; in_ds = 1'b1; inst_valid = 1'b1; inst_pc = 32'h204;
      expect_cyc("ds_take", 0, 0, 0, 0, 1, 0, 0);
      tick(); clr_in();
      expect_cyc("ds_epc", 1, 14, 32'h200, 0, 1, 0, 0);
      tick();
      expect_cyc("ds_cause", 1, 13, 32'h8000_0020, 1, 1, 0, 0);
      tick();
      expect_cyc("ds_status", 1, 12, 32'h2, 0, 1, 0, 0);
      tick();
      expect_cyc("ds_flush", 0, 0, 0, 0, 0, 1, 32'h20);
      tick();
      expect_cyc("ds_idle", 0, 0, 0, 0, 0, 0, 0);
      drain();
   endtask

   task automatic test_nested_exl();
      tick(); status = 32'h2; exc_req = 1'b1; exc_code = 5'd4; inst_valid = 1'b1; inst_pc = 32'h50;
      expect_cyc("exl_take", 0, 0, 0, 0, 1, 0, 0);
      tick(); clr_in();
      expect_cyc("exl_cause", 1, 13, 32'h10, 1, 1, 0, 0);
      tick();
      expect_cyc("exl_status", 1, 12, 32'h2, 0, 1, 0, 0);
      tick();
      expect_cyc("exl_flush", 0, 0, 0, 0, 0, 1, 32'h20);
      tick(); status = '0;
      expect_cyc("exl_idle", 0, 0, 0, 0, 0, 0, 0);
      drain();
   endtask

   task automatic test_eret();
      tick(); status = 32'h3; epc = 32'h300; eret = 1'b1; inst_valid = 1'b1; inst_pc = 32'h80;
      expect_cyc("eret_take", 0, 0, 0, 0, 1, 0, 0);
      tick(); clr_in();
      expect_cyc("eret_status", 1, 12, 32'h1, 0, 1, 0, 0);
      tick(); status = 32'h1; epc = 32'hDEAD_0000;
      expect_cyc("eret_flush", 0, 0, 0, 0, 0, 1, 32'h300);
      tick(); status = '0; epc = '0;
      expect_cyc("eret_idle", 0, 0, 0, 0, 0, 0, 0);
      drain();
   endtask

   task automatic test_mtc0();
      tick(); mtc0_we = 1'b1; mtc0_addr = 5'd11; mtc0_data = 32'hABCD;
      expect_cyc("mtc0_idle_pass", 1, 11, 32'hABCD, 0, 0, 0, 0);
      tick(); clr_in(); status = 32'h1;
      exc_req = 1'b1; exc_code = 5'd10; inst_valid = 1'b1; inst_pc = 32'h700;
      mtc0_we = 1'b1; mtc0_addr = 5'd12; mtc0_data = 32'h0;
      expect_cyc("mtc0_take_cycle", 1, 12, 32'h0, 0, 1, 0, 0);
      tick(); clr_in(); status = 32'h0;
      expect_cyc("mtc0_epc", 1, 14, 32'h700, 0, 1, 0, 0);
      tick();
      expect_cyc("mtc0_cause", 1, 13, 32'h28, 1, 1, 0, 0);
      tick();
      expect_cyc("mtc0_status", 1, 12, 32'h2, 0, 1, 0, 0);
      tick();
      expect_cyc("mtc0_flush", 0, 0, 0, 0, 0, 1, 32'h20);
      drain();
   endtask

   task automatic test_back_to_back();
      tick(); status = 32'h0000_8001; cause = 32'h0000_8000;
      exc_req = 1'b1; exc_code = 5'd12; eret = 1'b1; inst_valid = 1'b1; inst_pc = 32'h400;
      expect_cyc("prio_take", 0, 0, 0, 0, 1, 0, 0);
      tick(); clr_in();
      expect_cyc("prio_epc", 1, 14, 32'h400, 0, 1, 0, 0);
      tick();
      expect_cyc("prio_cause_int_code", 1, 13, 32'h8000, 1, 1, 0, 0);
      tick();
      expect_cyc("prio_status", 1, 12, 32'h8003, 0, 1, 0, 0);
      tick(); status = 32'h0000_8003;
      expect_cyc("prio_flush", 0, 0, 0, 0, 0, 1, 32'h20);
      tick(); exc_req = 1'b1; exc_code = 5'd2; inst_valid = 1'b1; inst_pc = 32'h500;
      expect_cyc("b2b_take", 0, 0, 0, 0, 1, 0, 0);
      tick(); clr_in();
      expect_cyc("b2b_cause", 1, 13, 32'h8008, 1, 1, 0, 0);
      tick();
      expect_cyc("b2b_status", 1, 12, 32'h8003, 0, 1, 0, 0);
      tick();
      expect_cyc("b2b_flush", 0, 0, 0, 0, 0, 1, 32'h20);
      tick(); status = '0; cause = '0;
      expect_cyc("b2b_idle", 0, 0, 0, 0, 0, 0, 0);
      drain();
   endtask

   task automatic test_reset_abort();
      tick(); exc_req = 1'b1; exc_code = 5'd8; inst_valid = 1'b1; inst_pc = 32'h600;
      expect_cyc("abort_take", 0, 0, 0, 0, 1, 0, 0);
      tick(); clr_in();
      expect_cyc("abort_epc", 1, 14, 32'h600, 0, 1, 0, 0);
      tick();
      #2;
      rst = 1'b1;
      #1;
      n_assert++;
      if (cp0_we !== 1'b0 || cp0_exc_wr !== 1'b0 || cp0_waddr !== 5'd0 || cp0_data !== 32'h0) begin
         n_fail++;
         $display("FAIL abort_async_write: got we=%b xw=%b a=%0d d=%h, expected 0", cp0_we, cp0_exc_wr, cp0_waddr, cp0_data);
      end
      n_assert++;
      if (stall !== 1'b0 || flush !== 1'b0 || new_pc !== 32'h0) begin
         n_fail++;
         $display("FAIL abort_async_ctrl: got st=%b fl=%b pc=%h, expected 0", stall, flush, new_pc);
      end
`ifdef CP0_EXC_STAT_EN
      n_assert++;
      if (exc_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL abort_cnt_reset: got %0d, expected 0", exc_cnt);
      end
`endif
      tick(); rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         expect_cyc("abort_quiet", 0, 0, 0, 0, 0, 0, 0);
         tick();
      end
      expect_cyc("abort_quiet", 0, 0, 0, 0, 0, 0, 0);
      drain();
      tick(); status = 32'h2; exc_req = 1'b1; exc_code = 5'd1; inst_valid = 1'b1; inst_pc = 32'h40;
      expect_cyc("cnt_take", 0, 0, 0, 0, 1, 0, 0);
      tick(); clr_in();
      expect_cyc("cnt_cause", 1, 13, 32'h4, 1, 1, 0, 0);
      tick();
      expect_cyc("cnt_status", 1, 12, 32'h2, 0, 1, 0, 0);
      tick();
      expect_cyc("cnt_flush", 0, 0, 0, 0, 0, 1, 32'h20);
      tick(); status = '0;
      expect_cyc("cnt_idle", 0, 0, 0, 0, 0, 0, 0);
      drain();
`ifdef CP0_EXC_STAT_EN
      n_assert++;
      if (exc_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL cnt_one: got %0d, expected 1", exc_cnt);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_interrupt();
      test_exc_delay_slot();
      test_nested_exl();
      test_eret();
      test_mtc0();
      test_back_to_back();
      test_reset_abort();
      repeat (2) @(posedge clk);
      if (exp_q.size() != 0) begin
         n_assert++;
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
